// File: rtl/sram_page_dma.sv
// Page-to-page SRAM copy/fill engine with absolute host priority on the SRAM port.
// Optional fill mode compiled in with `define FILL_MODE_EN.
module sram_page_dma (
  input  logic        clk,
  input  logic        nrst,
  input  logic        io_wr,
  input  logic [1:0]  io_addr,
  input  logic [7:0]  io_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [19:0] host_addr,
  input  logic [7:0]  sram_rdata,
  output logic [19:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  sram_wdata,
  output logic        sram_wdata_oe,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | no transfer; SRAM strobes released unless host owns the bus
  // RD    | read SRC page byte at offset into hold register
  // WR    | write hold (copy) or FILL (fill) to DST page at offset
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]  r_state;
  logic [6:0]  r_src;
  logic [6:0]  r_dst;
  logic [12:0] r_offset;
  logic [7:0]  r_hold;
  logic        r_done;

  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_last;
  logic        w_fill_sel;
  logic        w_start_fill;
  logic [7:0]  w_wdata;

  assign w_ctrl_wr = io_wr && (io_addr == 2'd2);
  assign w_start   = w_ctrl_wr && io_data[0] && !io_data[7] && (r_state == S_IDLE);
  assign w_abort   = w_ctrl_wr && io_data[7] && (r_state != S_IDLE);
  assign w_last    = (r_offset == 13'h1FFF);

`ifdef FILL_MODE_EN
  logic [7:0] r_fill;
  logic       r_fill_mode;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fill      <= 8'h00;
      r_fill_mode <= 1'b0;
    end else begin
      if (io_wr && (io_addr == 2'd3))
        r_fill <= io_data;
      if (!host_req && w_start)
        r_fill_mode <= io_data[1];
    end
  end

  assign w_fill_sel   = r_fill_mode;
  assign w_start_fill = io_data[1];
  assign w_wdata      = r_fill_mode ? r_fill : r_hold;
`else
  assign w_fill_sel   = 1'b0;
  assign w_start_fill = 1'b0;
  assign w_wdata      = r_hold;
`endif

  // Page registers are always writable; the engine only advances on host-free edges.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_src    <= 7'h00;
      r_dst    <= 7'h00;
      r_offset <= 13'h0000;
      r_hold   <= 8'h00;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (io_wr && (io_addr == 2'd0))
        r_src <= io_data[6:0];
      if (io_wr && (io_addr == 2'd1))
        r_dst <= io_data[6:0];
      if (!host_req) begin
        if (w_abort) begin
          r_state <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_start) begin
                r_offset <= 13'h0000;
                r_state  <= w_start_fill ? S_WR : S_RD;
              end
            end
            S_RD: begin
              r_hold  <= sram_rdata;
              r_state <= S_WR;
            end
            S_WR: begin
              if (w_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_offset <= r_offset + 13'd1;
                r_state  <= w_fill_sel ? S_WR : S_RD;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    sram_addr     = 20'h00000;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    sram_wdata_oe = 1'b0;
    if (host_req) begin
      sram_addr = host_addr;
      sram_ce_n = 1'b0;
      sram_oe_n = host_we;
      sram_we_n = !host_we;
    end else begin
      case (r_state)
        S_RD: begin
          sram_addr = {r_src, r_offset};
          sram_ce_n = 1'b0;
          sram_oe_n = 1'b0;
        end
        S_WR: begin
          sram_addr     = {r_dst, r_offset};
          sram_ce_n     = 1'b0;
          sram_we_n     = 1'b0;
          sram_wdata_oe = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sram_wdata = w_wdata;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_sram_page_dma.sv
// Directed-random bench for sram_page_dma against a page-level SRAM reference model.
module tb_sram_page_dma;

  logic        clk = 1'b0;
  logic        nrst;
  logic        io_wr;
  logic [1:0]  io_addr;
  logic [7:0]  io_data;
  logic        host_req;
  logic        host_we;
  logic [19:0] host_addr;
  logic [7:0]  sram_rdata;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  sram_wdata;
  logic        sram_wdata_oe;
  logic        busy, done;

  logic [7:0] mem      [0:1048575];
  logic [7:0] snap_src [0:8191];
  logic [7:0] snap_dst [0:8191];

  int n_pass  = 0;
  int n_total = 0;

  sram_page_dma dut (
    .clk(clk), .nrst(nrst), .io_wr(io_wr), .io_addr(io_addr), .io_data(io_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .sram_rdata(sram_rdata), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_wdata(sram_wdata),
    .sram_wdata_oe(sram_wdata_oe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write SRAM; only engine-driven writes carry data.
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_wdata_oe)
      mem[sram_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic io(input logic [1:0] a, input logic [7:0] d);
    io_wr = 1'b1; io_addr = a; io_data = d;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40000) begin
      tick();
      n++;
    end
  endtask

  task automatic snap(input logic [6:0] s, input logic [6:0] d);
    for (int o = 0; o < 8192; o++) begin
      snap_src[o] = mem[{s, o[12:0]}];
      snap_dst[o] = mem[{d, o[12:0]}];
    end
  endtask

  function automatic int copy_errs(input logic [6:0] pg, input int lo, input int hi);
    int e = 0;
    for (int o = lo; o <= hi; o++)
      if (mem[{pg, o[12:0]}] !== snap_src[o]) e++;
    return e;
  endfunction

  function automatic int keep_errs(input logic [6:0] pg, input int lo, input int hi);
    int e = 0;
    for (int o = lo; o <= hi; o++)
      if (mem[{pg, o[12:0]}] !== snap_dst[o]) e++;
    return e;
  endfunction

  function automatic int fill_errs(input logic [6:0] pg, input logic [7:0] v);
    int e = 0;
    for (int o = 0; o < 8192; o++)
      if (mem[{pg, o[12:0]}] !== v) e++;
    return e;
  endfunction

  initial begin
    int n, t, pulses;
    logic [6:0]  src, dst;
    logic [19:0] a_frozen;

    for (int i = 0; i < 1048576; i++) mem[i] = 8'($urandom);
    nrst = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_data = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 20'h0;
    #1;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #11 nrst = 1'b1;
    tick();

    // Copy 0x05 -> 0x12
    snap(7'h05, 7'h12);
    io(2'd0, 8'h05);
    io(2'd1, 8'h12);
    io(2'd2, 8'h01);
    check("copy_busy", busy, 1'b1);
    wait_done(n);
    check("copy_cycles", n, 16384);
    check("copy_busy_at_done", busy, 1'b0);
    check("copy_idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
    check("copy_dst_errs", copy_errs(7'h12, 0, 8191), 0);
    check("copy_src_errs", copy_errs(7'h05, 0, 8191), 0);
    tick();
    check("copy_done_pulse", done, 1'b0);

    // Contention + ignored restart during one copy
    src = 7'($urandom_range(0, 127));
    dst = src ^ 7'($urandom_range(1, 127));
    snap(src, dst);
    io(2'd0, {1'b0, src});
    io(2'd1, {1'b0, dst});
    io(2'd2, 8'h01);
    for (int i = 0; i < 1001; i++) tick();
    check("cont_pre_addr", sram_addr, {dst, 13'd500});
    a_frozen = sram_addr;
    for (int i = 0; i < 10; i++) begin
      host_req = 1'b1; host_we = (i >= 5); host_addr = 20'($urandom);
      #1;
      check("host_addr", sram_addr, host_addr);
      check("host_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe},
            {1'b0, host_we, !host_we, 1'b0});
      tick();
    end
    host_req = 1'b0; host_we = 1'b0;
    #1;
    check("cont_frozen_addr", sram_addr, a_frozen);
    check("cont_busy", busy, 1'b1);
    io(2'd2, 8'h01);
    wait_done(n);
    t = 1001 + 10 + 1 + n;
    check("cont_cycles", t, 16384 + 10);
    check("cont_dst_errs", copy_errs(dst, 0, 8191), 0);

    // CTRL=0x03: fill when compiled in, plain copy otherwise
    src = 7'($urandom_range(0, 126));
    snap(src, 7'h7F);
    io(2'd3, 8'hA5);
    io(2'd0, {1'b0, src});
    io(2'd1, 8'h7F);
    io(2'd2, 8'h03);
    wait_done(n);
`ifdef FILL_MODE_EN
    check("fill_cycles", n, 8192);
    check("fill_errs", fill_errs(7'h7F, 8'hA5), 0);
`else
    check("nofill_cycles", n, 16384);
    check("nofill_dst_errs", copy_errs(7'h7F, 0, 8191), 0);
`endif

    // Abort at offset 0x100
    src = 7'($urandom_range(0, 127));
    dst = src ^ 7'($urandom_range(1, 127));
    snap(src, dst);
    io(2'd0, {1'b0, src});
    io(2'd1, {1'b0, dst});
    io(2'd2, 8'h01);
    for (int i = 0; i < 512; i++) tick();
    check("abort_at_addr", sram_addr, {src, 13'h100});
    io(2'd2, 8'h80);
    check("abort_busy", busy, 1'b0);
    check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort_no_done", pulses, 0);
    check("abort_copied_errs", copy_errs(dst, 0, 255), 0);
    check("abort_untouched_errs", keep_errs(dst, 257, 8191), 0);

    // Asynchronous reset during WR
    io(2'd0, 8'h33);
    io(2'd1, 8'h44);
    io(2'd3, 8'h5A);
    io(2'd2, 8'h01);
    for (int i = 0; i < 11; i++) tick();
    check("rstwr_in_wr", {sram_we_n, sram_addr}, {1'b0, 7'h44, 13'd5});
    nrst = 1'b0;
    #2;
    check("rstwr_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
    check("rstwr_busy", busy, 1'b0);
    check("rstwr_done", done, 1'b0);
    #2 nrst = 1'b1;
    tick();
    io(2'd2, 8'h01);
    check("rstwr_src_cleared", {sram_oe_n, sram_addr}, 21'h0);
    tick();
    check("rstwr_dst_cleared", {sram_we_n, sram_addr}, 21'h0);
    check("rstwr_hold_data", sram_wdata, mem[0]);
    io(2'd2, 8'h80);
    check("rstwr_abort_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_page_dma.md
SRAM_PAGE_DMA -- requirements
Module: sram_page_dma

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port io_wr  input  1  one-cycle strobe, I/O write decoded to ports F8-FB.
REQ-004 SHALL have port io_addr  input  2  register select: 0=SRC page, 1=DST page, 2=CTRL, 3=FILL byte.
REQ-005 SHALL have port io_data  input  8  I/O write data.
REQ-006 SHALL have port host_req  input  1  host memory cycle active (decoded chip-enable of the bank mapper).
REQ-007 SHALL have port host_we  input  1  host cycle is a write.
REQ-008 SHALL have port host_addr  input  20  host SRAM address {page[6:0], offset[12:0]}.
REQ-009 SHALL have port sram_rdata  input  8  SRAM read data.
REQ-010 SHALL have port sram_addr  output  20  SRAM address.
REQ-011 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active-low.
REQ-012 SHALL have port sram_wdata  output  8  engine write data.
REQ-013 SHALL have port sram_wdata_oe  output  1  engine drives SRAM data bus.
REQ-014 SHALL have port busy  output  1  engine transfer in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL keep registers SRC[6:0], DST[6:0], FILL[7:0]; io_wr writes the selected register in the next edge.
REQ-017 SHALL implement states IDLE, RD, WR; transitions occur only on edges without host_req.
REQ-018 SHALL, on a CTRL write with bit0=1 in IDLE, clear the 13-bit offset counter and enter RD (copy) or WR (fill when bit1=1); busy SHALL be 1 from the next cycle.
REQ-019 SHALL ignore CTRL start writes while busy.
REQ-020 SHALL, in RD, drive {SRC,offset}, ce_n=0, oe_n=0, latch sram_rdata into a hold register at the edge, and go to WR.
REQ-021 SHALL, in WR, drive {DST,offset}, ce_n=0, we_n=0, sram_wdata=hold (copy) or FILL (fill), sram_wdata_oe=1.
REQ-022 SHALL, after WR, increment offset and return to RD (copy) or remain in WR (fill); at offset 8191 it SHALL go to IDLE, clear busy and pulse done.
REQ-023 SHALL give host_req absolute priority: combinationally pass host_addr, ce_n=0, oe_n=host_we, we_n=!host_we, sram_wdata_oe=0; the engine SHALL hold state, offset and hold register unchanged.
REQ-024 SHALL, on a CTRL write with bit7=1 while busy, return to IDLE next edge with busy=0 and no done pulse; bit7 has priority over bit0.
REQ-025 SHALL treat SRC==DST as legal (bytes rewritten unchanged).
REQ-026 SHALL deassert all SRAM strobes (1) and sram_wdata_oe (0) in IDLE without host_req.
REQ-027 SHALL take 16384 uncontended cycles per copy and 8192 per fill from busy rising to done.
REQ-028 SHALL accept SRC/DST/FILL writes while busy; these take effect from the next access.

Reset
REQ-029 SHALL on nrst=0 asynchronously set state=IDLE, SRC=DST=FILL=0, offset=0, hold=0, busy=0, done=0.
REQ-030 SHALL, on reset mid-transfer, abandon it with no done pulse; SRAM contents are not restored.

Configuration
REQ-031 SHALL compile fill mode only when FILL_MODE_EN is defined; without it, CTRL bit1 and FILL writes SHALL be ignored and every start SHALL be a copy.

Verification
REQ-032 SHALL verify copy: SRC=0x05, DST=0x12, CTRL=0x01 -> page 0x12 equals page 0x05, done after 16384 cycles.
REQ-033 SHALL verify fill (FILL_MODE_EN): FILL=0xA5, DST=0x7F, CTRL=0x03 -> 0xFE000-0xFFFFF all 0xA5, done after 8192 cycles.
REQ-034 SHALL verify contention: host_req held 10 cycles mid-copy -> sram_addr=host_addr, offset frozen, done delayed exactly 10 cycles.
REQ-035 SHALL verify abort: CTRL=0x80 at offset 0x0100 -> busy=0 next cycle, no done, bytes at offset >=0x0101 unchanged.
REQ-036 SHALL verify reset: nrst low during WR -> all strobes 1, busy=0 immediately, registers 0.
REQ-037 SHALL verify ignored start: CTRL=0x01 while busy -> transfer length and done timing unchanged.
